// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 datapath blocks.
//   DATA_WIDTH : default datapath width
//   OP_ADD/SUB : encodings of the sub_i strobe
package sap1_pkg;
    localparam int   DATA_WIDTH = 8;
    localparam logic OP_ADD     = 1'b0;
    localparam logic OP_SUB     = 1'b1;
endpackage

// File: rtl/alu_accumulator_if.sv
// Controller <-> ALU signal bundle.
//   master : controller side, drives bus data and strobes, reads registers/flags
//   slave  : ALU side
interface alu_accumulator_if #(
    parameter int WIDTH = sap1_pkg::DATA_WIDTH
);
    logic [WIDTH-1:0] bus_i;
    logic             load_a_i;
    logic             load_b_i;
    logic             sub_i;
    logic             latch_i;
    logic [WIDTH-1:0] a_o;
    logic [WIDTH-1:0] b_o;
    logic [WIDTH-1:0] result_o;
    logic             carry_o;
    logic             zero_o;
    logic             overflow_o;

    modport master (
        output bus_i, load_a_i, load_b_i, sub_i, latch_i,
        input  a_o, b_o, result_o, carry_o, zero_o, overflow_o
    );

    modport slave (
        input  bus_i, load_a_i, load_b_i, sub_i, latch_i,
        output a_o, b_o, result_o, carry_o, zero_o, overflow_o
    );
endinterface

// File: rtl/ripple_adder.sv
// Combinational WIDTH-bit ripple-carry adder.
//   a_i, b_i   : operands
//   carry_i    : carry into bit 0
//   sum_o      : a_i + b_i + carry_i, truncated
//   carry_o    : carry out of the MSB
//   overflow_o : signed overflow (carry into MSB differs from carry out)
module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             overflow_o
);
    logic [WIDTH:0] c;

    // Chain kept inside one block so the carry vector is not a
    // combinational self-loop across separate assigns.
    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = carry_i;
        for (int i = 0; i < WIDTH; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
            c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign carry_o    = c[WIDTH];
    assign overflow_o = c[WIDTH] ^ c[WIDTH-1];
endmodule

// File: rtl/alu_accumulator.sv
// SAP-1 accumulator ALU: A/B operand registers, add/sub, registered flags,
// result write-back into A.
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset (A=B=0, carry=ovf=0, zero=1)
//   io    : strobes/bus in, A, B, combinational result and flags out
// latch_i beats load_a_i for A; load_b_i is independent and a latch in the
// same cycle uses the pre-edge B.
module alu_accumulator
    import sap1_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic                clk_i,
    input  logic                rst_i,
    alu_accumulator_if.slave    io
);
    logic [WIDTH-1:0] a_q, b_q, b_eff, sum;
    logic             carry_q, zero_q, ovf_q;
    logic             sub, add_carry, add_ovf;

    assign sub   = (io.sub_i == OP_SUB);
    // Subtraction as A + ~B + 1; the +1 enters as carry-in.
    assign b_eff = b_q ^ {WIDTH{sub}};

    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .a_i        (a_q),
        .b_i        (b_eff),
        .carry_i    (sub),
        .sum_o      (sum),
        .carry_o    (add_carry),
        .overflow_o (add_ovf)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            if (io.latch_i) begin
                a_q     <= sum;
                carry_q <= add_carry;
                zero_q  <= (sum == '0);
                ovf_q   <= add_ovf;
            end else if (io.load_a_i) begin
                a_q <= io.bus_i;
            end
            if (io.load_b_i)
                b_q <= io.bus_i;
        end
    end

    assign io.a_o        = a_q;
    assign io.b_o        = b_q;
    assign io.result_o   = sum;
    assign io.carry_o    = carry_q;
    assign io.zero_o     = zero_q;
    assign io.overflow_o = ovf_q;
endmodule

// File: doc/alu_accumulator.md
Name: alu_accumulator

Overview:
- Parametrised successor to the 1-bit combinational adder.
- WIDTH-bit adder/subtractor with A (accumulator) and B operand registers, registered status flags, and write-back of the result into A.
- Sits in the SAP-1 datapath between the W bus and the output/flag logic.
- Driven by controller strobes: load A, load B, subtract, latch result.

Parameters:
- WIDTH, 8: datapath width in bits; legal range 2 to 32.

Ports:
- clk_i  input  1  system clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- bus_i  input  WIDTH  operand data from the W bus.
- load_a_i  input  1  A <= bus_i at the next edge.
- load_b_i  input  1  B <= bus_i at the next edge.
- sub_i  input  1  0 = A+B, 1 = A-B (two's complement: A + ~B + 1).
- latch_i  input  1  A <= result and flags update at the next edge.
- a_o  output  WIDTH  current A register.
- b_o  output  WIDTH  current B register.
- result_o  output  WIDTH  combinational A op B, truncated to WIDTH.
- carry_o  output  1  registered carry-out.
- zero_o  output  1  registered; 1 when the latched result == 0.
- overflow_o  output  1  registered signed overflow.

Behaviour:
- Reset: on a rising edge with rst_i=1:
  - A, B, carry_o and overflow_o go to 0; zero_o goes to 1.
  - result_o therefore reads 0 after reset.
  - Reset overrides every other strobe in that cycle.
- Result path: result_o = (A + (B XOR {WIDTH{sub_i}}) + sub_i) mod 2^WIDTH.
  - Purely combinational, zero latency.
  - Follows sub_i, A and B immediately.
- Carry: the (WIDTH+1)th bit of the same sum.
  - For subtraction, carry=1 means no borrow (A >= B, unsigned).
- Overflow: operands of equal effective sign produce a result of opposite sign.
  - Effective operand is B for add, ~B for sub.
- latch_i=1 at an edge:
  - A <= result_o.
  - carry_o, zero_o and overflow_o all update from that same result.
  - Flags hold their values whenever latch_i=0.
- load_a_i=1 at an edge: A <= bus_i; flags unchanged.
- load_b_i=1 at an edge: B <= bus_i; independent of A activity.
- Priority when latch_i and load_a_i are both 1: latch_i wins; A takes the result; load_a_i is ignored.
- load_b_i together with latch_i:
  - B takes bus_i.
  - The latched result uses the pre-edge B.
- Wrap-around, WIDTH=8: 0xFF+0x01 -> result 0x00, carry 1, zero 1, overflow 0.
- Mid-sequence reset: discards pending strobes; next cycle shows reset values.
- Latency:
  - Load to a_o/b_o: 1 cycle.
  - Latch to flags and a_o: 1 cycle.
  - Operands to result_o: 0 cycles.

Decomposition:
- Package sap1_pkg holds:
  - DATA_WIDTH default (8).
  - OP_ADD=1'b0 and OP_SUB=1'b1 constants for sub_i.
- Sub-module ripple_adder (parameter WIDTH):
  - Inputs a_i, b_i, carry_i.
  - Outputs sum_o, carry_o, overflow_o.
  - Purely combinational.
- alu_accumulator holds:
  - The registers A, B and the flags.
  - The B inversion.
  - The priority logic.

Test Plan:
- Reset: assert rst_i one cycle with load strobes high and bus_i=0xAA -> a_o=0x00, b_o=0x00, carry_o=0, zero_o=1, overflow_o=0.
- Add and latch: load A=0x12, load B=0x34, sub_i=0.
  - result_o=0x46 combinationally.
  - Pulse latch_i -> a_o=0x46, carry_o=0, zero_o=0, overflow_o=0.
- Unsigned wrap: A=0xFF, B=0x01, add, latch -> a_o=0x00, carry_o=1, zero_o=1, overflow_o=0.
- Subtract with borrow and signed overflow:
  - A=0x05, B=0x07, sub_i=1, latch -> a_o=0xFE, carry_o=0, overflow_o=0.
  - Then A=0x80, B=0x01, sub, latch -> a_o=0x7F, carry_o=1, overflow_o=1.
- Simultaneous strobes: A=0x10, B=0x01, bus_i=0x55, latch_i=load_a_i=load_b_i=1 in one cycle -> a_o=0x11, b_o=0x55, flags from 0x11.
- Flag hold and parameter sweep:
  - After a latch, toggle sub_i and load A/B without latch_i -> flags unchanged.
  - Repeat the wrap test at WIDTH=4: 0xF+0x1 -> 0x0, carry 1.
